// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-stage requests -> per-register enables.
// Optional stall watchdog enabled by defining PIPE_CTRL_WATCHDOG_EN.
module pipe_hazard_ctrl #(
  parameter int STAGES = 7,
  parameter logic [STAGES-1:0] DECOUPLE_MASK = STAGES'(7'b0001000),
  parameter int WDOG_LIMIT = 1024,
  parameter int WDOG_W = $clog2(WDOG_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stall_out,
  output logic [STAGES-1:0] flush_out,
  output logic              hold_pending,
  output logic              wdog_timeout
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [STAGES-1:0] pend_mask;
  logic [STAGES-1:0] pend_nxt;
  logic [STAGES-1:0] stall_raw;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] flush_now;
  logic [STAGES-1:0] flush_all;
  logic [STAGES-1:0] pend_low;
  logic              qual;
  logic              stall_above;

  // Span from the nearest buffer at or below k up to k.
  function automatic logic [STAGES-1:0] stall_span(input int k);
    logic [STAGES-1:0] m;
    int b;
    b = 0;
    for (int d = 0; d < STAGES; d++)
      if (d <= k && DECOUPLE_MASK[d]) b = d;
    m = '0;
    for (int i = 0; i < STAGES; i++)
      if (i >= b && i <= k) m[i] = 1'b1;
    return m;
  endfunction

  always_comb begin
    stall_raw = '0;
    for (int k = 0; k < STAGES; k++)
      if (stall_req[k]) stall_raw = stall_raw | stall_span(k);
  end

  always_comb begin
    bubble = '0;
    for (int k = 0; k < STAGES - 1; k++)
      if (stall_req[k] && !stall_raw[k+1] && !DECOUPLE_MASK[k+1])
        bubble[k+1] = 1'b1;
  end

  always_comb begin
    flush_now = '0;
    for (int i = 1; i < STAGES; i++)
      for (int k = i; k < STAGES; k++)
        if (flush_req[k]) flush_now[i] = 1'b1;
  end

  assign flush_all = flush_now | pend_mask;

  // A flush qualifies for latching when a stall sits above it.
  always_comb begin
    qual = 1'b0;
    for (int k = 0; k < STAGES; k++)
      for (int j = 0; j < STAGES; j++)
        if (j > k && flush_req[k] && stall_req[j]) qual = 1'b1;
  end

  // pend_low: all bits at or below the highest pending bit.
  always_comb begin
    pend_low = '0;
    for (int i = STAGES - 1; i >= 0; i--)
      pend_low[i] = pend_mask[i] | ((i < STAGES - 1) ? pend_low[i+1] : 1'b0);
  end

  assign stall_above = |(stall_req & ~pend_low);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pend_mask <= '0;
    end else begin
      state     <= state_nxt;
      pend_mask <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_mask;
    unique case (state)
      RUN: begin
        if (qual) begin
          pend_nxt  = pend_mask | flush_now;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (qual) begin
          pend_nxt = pend_mask | flush_now;
        end else if (!stall_above) begin
          pend_nxt  = '0;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        pend_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    stall_out    = '0;
    flush_out    = '0;
    hold_pending = 1'b0;
    if (rst) begin
      flush_out = {{(STAGES-1){1'b1}}, 1'b0};
    end else begin
      stall_out    = stall_raw & ~flush_all;
      flush_out    = bubble | flush_all;
      hold_pending = (state == HOLD);
    end
  end

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] LIM = WDOG_W'(WDOG_LIMIT);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else begin
      if (wdog_cnt == LIM) wdog_flag <= 1'b1;
      if (|stall_out) begin
        if (wdog_cnt != LIM) wdog_cnt <= wdog_cnt + 1'b1;
      end else begin
        wdog_cnt <= '0;
      end
    end
  end

  assign wdog_timeout = wdog_flag;
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases plus random traffic
// against an index-arithmetic reference model.
module tb_pipe_hazard_ctrl;

  localparam int N = 7;
  localparam logic [N-1:0] DM = 7'h08;
  localparam int LIMIT = 4;
`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] stall_req;
  logic [N-1:0] flush_req;
  logic [N-1:0] stall_out;
  logic [N-1:0] flush_out;
  logic         hold_pending;
  logic         wdog_timeout;

  pipe_hazard_ctrl #(
    .STAGES(N),
    .DECOUPLE_MASK(DM),
    .WDOG_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_req(stall_req),
    .flush_req(flush_req),
    .stall_out(stall_out),
    .flush_out(flush_out),
    .hold_pending(hold_pending),
    .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] m_pend;
  bit           m_hold;
  int           m_cnt;
  bit           m_to;
  logic [N-1:0] e_stall, e_flush, e_fn;
  logic         e_hold, e_to;

  function automatic int hi_bit(input logic [N-1:0] m);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int lo_bit(input logic [N-1:0] m);
    int r;
    r = N;
    for (int i = N - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int base_of(input int k);
    int b;
    b = 0;
    for (int d = 0; d <= k; d++) if (DM[d]) b = d;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    logic [N-1:0] raw, bub, fn, all;
    raw = '0; bub = '0; fn = '0;
    for (int k = 0; k < N; k++)
      if (stall_req[k])
        for (int i = base_of(k); i <= k; i++) raw[i] = 1'b1;
    for (int k = 0; k + 1 < N; k++)
      if (stall_req[k] && !raw[k+1] && !DM[k+1]) bub[k+1] = 1'b1;
    for (int k = 0; k < N; k++)
      if (flush_req[k])
        for (int i = 1; i <= k; i++) fn[i] = 1'b1;
    all = fn | m_pend;
    e_fn = fn;
    if (rst) begin
      e_stall = '0;
      e_flush = 7'h7E;
      e_hold  = 1'b0;
    end else begin
      e_stall = raw & ~all;
      e_flush = bub | all;
      e_hold  = m_hold;
    end
    e_to = WD ? m_to : 1'b0;
  endtask

  task automatic model_step();
    bit qual;
    model_eval();
    if (rst) begin
      m_pend = '0; m_hold = 0; m_cnt = 0; m_to = 0;
    end else begin
      qual = (flush_req != 0) && (stall_req != 0) &&
             (lo_bit(flush_req) < hi_bit(stall_req));
      if (qual) begin
        m_pend = m_pend | e_fn;
        m_hold = 1;
      end else if (m_hold && hi_bit(stall_req) <= hi_bit(m_pend)) begin
        m_hold = 0;
        m_pend = '0;
      end
      if (m_cnt == LIMIT) m_to = 1;
      if (e_stall != 0) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      else m_cnt = 0;
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".stall"}, 32'(stall_out), 32'(e_stall));
    chk({tag, ".flush"}, 32'(flush_out), 32'(e_flush));
    chk({tag, ".hold"}, 32'(hold_pending), 32'(e_hold));
    chk({tag, ".wdog"}, 32'(wdog_timeout), 32'(e_to));
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    m_pend = '0; m_hold = 0; m_cnt = 0; m_to = 0;
    rst = 1'b1; stall_req = '0; flush_req = '0;
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.stall", 32'(stall_out), 32'h00);
      chk("rst.flush", 32'(flush_out), 32'h7E);
      chk("rst.hold", 32'(hold_pending), 32'h0);
      adv();
    end
    rst = 1'b0;
    sample("idle");
    chk("idle.wdog0", 32'(wdog_timeout), 32'h0);
    adv();

    stall_req = 7'h20;
    sample("miss");
    chk("miss.stall", 32'(stall_out), 32'h38);
    chk("miss.flush", 32'(flush_out), 32'h40);
    adv();

    stall_req = 7'h04;
    sample("iqfull");
    chk("iqfull.stall", 32'(stall_out), 32'h07);
    chk("iqfull.flush", 32'(flush_out), 32'h00);
    adv();

    stall_req = 7'h40;
    sample("last");
    chk("last.stall", 32'(stall_out), 32'h78);
    chk("last.flush", 32'(flush_out), 32'h00);
    adv();

    stall_req = 7'h20; flush_req = 7'h20;
    sample("samek");
    chk("samek.stall", 32'(stall_out), 32'h00);
    chk("samek.flush", 32'(flush_out), 32'h7E);
    adv();

    stall_req = '0; flush_req = 7'h10;
    sample("br");
    chk("br.flush", 32'(flush_out), 32'h1E);
    chk("br.stall", 32'(stall_out), 32'h00);
    adv();
    flush_req = '0;
    sample("br1");
    chk("br1.flush", 32'(flush_out), 32'h00);
    adv();

    stall_req = 7'h20; flush_req = 7'h10;
    sample("hc0");
    chk("hc0.flush", 32'(flush_out), 32'h5E);
    chk("hc0.stall", 32'(stall_out), 32'h20);
    chk("hc0.hold", 32'(hold_pending), 32'h0);
    adv();
    flush_req = '0;
    for (int c = 1; c <= 2; c++) begin
      sample("hc12");
      chk("hc12.flush", 32'(flush_out), 32'h5E);
      chk("hc12.stall", 32'(stall_out), 32'h20);
      chk("hc12.hold", 32'(hold_pending), 32'h1);
      adv();
    end
    stall_req = '0;
    sample("hc3");
    chk("hc3.flush", 32'(flush_out), 32'h1E);
    adv();
    sample("hc4");
    chk("hc4.flush", 32'(flush_out), 32'h00);
    chk("hc4.hold", 32'(hold_pending), 32'h0);
    adv();

`ifdef PIPE_CTRL_WATCHDOG_EN
    rst = 1'b1;
    adv();
    rst = 1'b0;
    stall_req = 7'h20;
    for (int c = 1; c <= 5; c++) begin
      sample("wd");
      chk("wd.pre", 32'(wdog_timeout), 32'h0);
      adv();
    end
    stall_req = '0;
    for (int c = 0; c < 3; c++) begin
      sample("wd.post");
      chk("wd.sticky", 32'(wdog_timeout), 32'h1);
      adv();
    end
`endif

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int b = 0; b < N; b++)
        stall_req[b] = ($urandom_range(0, 5) == 0);
      flush_req = '0;
      if ($urandom_range(0, 3) == 0)
        flush_req[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0)
        flush_req[$urandom_range(0, N - 1)] = 1'b1;
      sample("rnd");
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
